// File: rtl/gpio_strobe_sched_pkg.sv
// Shared types and helpers for the debug strobe scheduler.
package gpio_strobe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    SEP   = 2'd3
  } strobe_state_e;

  localparam int DROP_W = 8;

  // Requester i blinks i+2 times; the heartbeat (id == n_req) blinks once.
  function automatic int pulse_count(input int id, input int n_req);
    return (id == n_req) ? 1 : id + 2;
  endfunction

endpackage

// File: rtl/gpio_strobe_sched_if.sv
// Event/status bundle between the debug event sources and the strobe scheduler.
interface gpio_strobe_sched_if
  import gpio_strobe_pkg::*;
#(
  parameter int N_REQ = 4
) ();
  localparam int ID_W = $clog2(N_REQ + 1);

  logic               enable;
  logic [N_REQ-1:0]   event_i;
  logic               strobe;
  logic               busy;
  logic [ID_W-1:0]    grant_id;
  logic [N_REQ-1:0]   pending;
  logic [DROP_W-1:0]  drop_cnt;

  modport master (
    output enable, event_i,
    input  strobe, busy, grant_id, pending, drop_cnt
  );

  modport slave (
    input  enable, event_i,
    output strobe, busy, grant_id, pending, drop_cnt
  );
endinterface

// File: rtl/gpio_strobe_sched_pattern_gen.sv
// Plays one pulse-count pattern: PULSE/GAP repeated, then a SEP quiet time.
module strobe_pattern_gen
  import gpio_strobe_pkg::*;
#(
  parameter int PULSE_LEN = 5000000,
  parameter int GAP_LEN   = 5000000,
  parameter int SEP_LEN   = 20000000,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pulse_cnt,
  output logic             strobe,
  output logic             busy
);
  localparam int MAX_PG  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int MAX_LEN = (MAX_PG > SEP_LEN) ? MAX_PG : SEP_LEN;
  localparam int TMR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [TMR_W-1:0] P_LD = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] G_LD = TMR_W'(GAP_LEN - 1);
  localparam logic [TMR_W-1:0] S_LD = TMR_W'(SEP_LEN - 1);

  strobe_state_e    state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             strobe_q, strobe_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      left_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      left_q   <= left_d;
      strobe_q <= strobe_d;
    end
  end

  // Timers count down to zero; left_q holds pulses still to play after this one.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    left_d   = left_q;
    strobe_d = strobe_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PULSE;
          timer_d  = P_LD;
          left_d   = pulse_cnt - CNT_W'(1);
          strobe_d = 1'b1;
        end
      end
      PULSE: begin
        if (timer_q == '0) begin
          strobe_d = 1'b0;
          if (left_q != '0) begin
            state_d = GAP;
            timer_d = G_LD;
            left_d  = left_q - CNT_W'(1);
          end else begin
            state_d = SEP;
            timer_d = S_LD;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          state_d  = PULSE;
          timer_d  = P_LD;
          strobe_d = 1'b1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      SEP: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - TMR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign strobe = strobe_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: rtl/gpio_strobe_sched.sv
// Latches debug events and a heartbeat, arbitrates by fixed priority and
// drives the spare header pin with a per-source pulse-count pattern.
module gpio_strobe_sched
  import gpio_strobe_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PULSE_LEN = 5000000,
  parameter int GAP_LEN   = 5000000,
  parameter int SEP_LEN   = 20000000,
  parameter int HB_PERIOD = 134217728
) (
  input logic             clk,
  input logic             rst,
  gpio_strobe_sched_if.slave bus
);
  localparam int ID_W  = $clog2(N_REQ + 1);
  localparam int CNT_W = $clog2(N_REQ + 2);
  localparam int HB_W  = $clog2(HB_PERIOD);

  logic [N_REQ-1:0]  pending_q, pending_d;
  logic              hb_pend_q, hb_pend_d;
  logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;

  logic              grant, hb_clr, hb_wrap, drop, pat_busy, pat_strobe;
  logic [ID_W-1:0]   winner;
  logic [N_REQ-1:0]  clr;
  logic [CNT_W-1:0]  start_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      hb_pend_q  <= 1'b0;
      hb_cnt_q   <= '0;
      drop_cnt_q <= '0;
      grant_id_q <= '0;
    end else begin
      pending_q  <= pending_d;
      hb_pend_q  <= hb_pend_d;
      hb_cnt_q   <= hb_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      grant_id_q <= grant_id_d;
    end
  end

  always_comb begin
    grant = bus.enable && !pat_busy && ((|pending_q) || hb_pend_q);

    // Lowest pending index wins; heartbeat (id N_REQ) only when nothing else is pending.
    winner = ID_W'(N_REQ);
    for (int i = N_REQ - 1; i >= 0; i--)
      if (pending_q[i]) winner = ID_W'(i);

    clr = '0;
    for (int i = 0; i < N_REQ; i++)
      clr[i] = grant && (winner == ID_W'(i));
    hb_clr = grant && (winner == ID_W'(N_REQ));

    // A bit being cleared this edge can be re-armed without counting a drop.
    pending_d  = (pending_q & ~clr) | bus.event_i;
    drop       = |(bus.event_i & pending_q & ~clr);
    drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + DROP_W'(1) : drop_cnt_q;

    hb_wrap   = (hb_cnt_q == HB_W'(HB_PERIOD - 1));
    hb_cnt_d  = hb_wrap ? '0 : hb_cnt_q + HB_W'(1);
    hb_pend_d = (hb_pend_q && !hb_clr) || hb_wrap;

    grant_id_d = grant ? winner : grant_id_q;
    start_cnt  = CNT_W'(pulse_count(int'(winner), N_REQ));
  end

  strobe_pattern_gen #(
    .PULSE_LEN (PULSE_LEN),
    .GAP_LEN   (GAP_LEN),
    .SEP_LEN   (SEP_LEN),
    .CNT_W     (CNT_W)
  ) u_pat (
    .clk       (clk),
    .rst       (rst),
    .start     (grant),
    .pulse_cnt (start_cnt),
    .strobe    (pat_strobe),
    .busy      (pat_busy)
  );

  assign bus.strobe   = pat_strobe;
  assign bus.busy     = pat_busy;
  assign bus.grant_id = grant_id_q;
  assign bus.pending  = pending_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_gpio_strobe_sched.sv
// Directed bench for gpio_strobe_sched with short timers (N_REQ=2, 3/2/4, HB=64).
module tb_gpio_strobe_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_strobe_sched_if #(.N_REQ(2)) bus ();

  gpio_strobe_sched #(
    .N_REQ(2), .PULSE_LEN(3), .GAP_LEN(2), .SEP_LEN(4), .HB_PERIOD(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hi_cnt = 0;
  int rises [4];
  logic prev_s = 1'b0;
  logic [15:0] s_rec, b_rec;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.strobe) hi_cnt++;
    if (bus.strobe && !prev_s) rises[bus.grant_id]++;
    prev_s = bus.strobe;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset(input logic en);
    rst = 1'b1;
    bus.event_i = '0;
    bus.enable  = en;
    #1;
    chk("rst_strobe",   32'(bus.strobe),   0);
    chk("rst_busy",     32'(bus.busy),     0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    chk("rst_pending",  32'(bus.pending),  0);
    chk("rst_drop",     32'(bus.drop_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    hi_cnt = 0;
    prev_s = 1'b0;
    foreach (rises[i]) rises[i] = 0;
  endtask

  initial begin
    rst = 1'b0;
    bus.enable  = 1'b1;
    bus.event_i = '0;
    #2;

    // Single event on requester 0
    do_reset(1'b1);
    bus.event_i = 2'b01;
    for (int c = 0; c < 16; c++) begin
      s_rec[c] = bus.strobe;
      b_rec[c] = bus.busy;
      if (c == 1) chk("single_pend_c1", 32'(bus.pending), 1);
      if (c == 2) chk("single_pend_c2", 32'(bus.pending), 0);
      tick();
      bus.event_i = '0;
    end
    chk("single_strobe_trace", 32'(s_rec), 32'h039C);
    chk("single_busy_trace",   32'(b_rec), 32'h3FFC);
    chk("single_grant_id",     32'(bus.grant_id), 0);
    chk("single_drop",         32'(bus.drop_cnt), 0);

    // Priority: both requesters at once
    do_reset(1'b1);
    bus.event_i = 2'b11;
    tick();
    bus.event_i = '0;
    goto(2);
    chk("prio_pend_first", 32'(bus.pending),  2);
    chk("prio_gid_first",  32'(bus.grant_id), 0);
    goto(15);
    chk("prio_strobe_c15", 32'(bus.strobe),   1);
    chk("prio_gid_second", 32'(bus.grant_id), 1);
    chk("prio_pend_clear", 32'(bus.pending),  0);
    goto(31);
    chk("prio_busy_c31",   32'(bus.busy),     1);
    goto(32);
    chk("prio_busy_c32",   32'(bus.busy),     0);
    chk("prio_rises_r0",   32'(rises[0]),     2);
    chk("prio_rises_r1",   32'(rises[1]),     3);

    // Drop counter saturation while requester 1 waits
    do_reset(1'b1);
    bus.event_i = 2'b11;
    tick();
    bus.event_i = '0;
    tick();
    bus.enable = 1'b0;
    chk("drop_pend_wait", 32'(bus.pending), 2);
    for (int k = 0; k < 300; k++) begin
      bus.event_i = 2'b10;
      tick();
    end
    bus.event_i = '0;
    tick();
    chk("drop_sat",        32'(bus.drop_cnt), 255);
    chk("drop_pend_held",  32'(bus.pending),  2);
    chk("drop_idle",       32'(bus.busy),     0);
    foreach (rises[i]) rises[i] = 0;
    bus.enable = 1'b1;
    goto(cyc + 60);
    chk("drop_r1_pulses",  32'(rises[1]),     3);
    chk("drop_r0_pulses",  32'(rises[0]),     0);
    chk("drop_sat_hold",   32'(bus.drop_cnt), 255);

    // Re-arm in the grant cycle
    do_reset(1'b1);
    bus.event_i = 2'b01;
    tick();
    tick();
    bus.event_i = '0;
    chk("rearm_pend",      32'(bus.pending),  1);
    chk("rearm_strobe",    32'(bus.strobe),   1);
    chk("rearm_drop",      32'(bus.drop_cnt), 0);
    goto(30);
    chk("rearm_rises",     32'(rises[0]),     4);
    chk("rearm_idle",      32'(bus.busy),     0);
    chk("rearm_drop_end",  32'(bus.drop_cnt), 0);

    // Heartbeat gated by enable
    do_reset(1'b0);
    goto(100);
    chk("hb_no_strobe",    32'(hi_cnt),       0);
    chk("hb_no_busy",      32'(bus.busy),     0);
    bus.enable = 1'b1;
    goto(101);
    chk("hb_strobe_c101",  32'(bus.strobe),   1);
    chk("hb_grant_id",     32'(bus.grant_id), 2);
    goto(103);
    chk("hb_strobe_c103",  32'(bus.strobe),   1);
    goto(104);
    chk("hb_strobe_c104",  32'(bus.strobe),   0);
    goto(108);
    chk("hb_idle_c108",    32'(bus.busy),     0);
    goto(128);
    chk("hb_strobe_c128",  32'(bus.strobe),   0);
    goto(129);
    chk("hb_strobe_c129",  32'(bus.strobe),   1);
    goto(132);
    chk("hb_strobe_c132",  32'(bus.strobe),   0);
    chk("hb_rises",        32'(rises[2]),     2);

    // Reset during the second pulse of requester 1
    do_reset(1'b1);
    bus.event_i = 2'b10;
    tick();
    bus.event_i = '0;
    goto(8);
    chk("mid_strobe_pre",  32'(bus.strobe),   1);
    chk("mid_gid_pre",     32'(bus.grant_id), 1);
    #2;
    do_reset(1'b1);
    bus.event_i = 2'b01;
    tick();
    bus.event_i = '0;
    goto(2);
    chk("mid_after_strobe", 32'(bus.strobe),   1);
    goto(16);
    chk("mid_after_rises",  32'(rises[0]),     2);
    chk("mid_after_gid",    32'(bus.grant_id), 0);
    chk("mid_after_idle",   32'(bus.busy),     0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
